// File: rtl/us_sync_pkg.sv
// rtl/us_sync_pkg.sv - shared constants and FSM state codes for the ultrasonic sync receiver
package us_sync_pkg;

  localparam int TS_W           = 32;
  localparam int CLK_HZ         = 50_000_000;
  localparam int CARRIER_HZ     = 40_000;
  localparam int CARRIER_PERIOD = CLK_HZ / CARRIER_HZ;

  // Accept +/-20% around the nominal carrier period by default.
  localparam int DEF_MIN_PERIOD = CARRIER_PERIOD * 4 / 5;
  localparam int DEF_MAX_PERIOD = CARRIER_PERIOD * 6 / 5;
  localparam int DEF_MIN_CYCLES = 8;
  localparam int DEF_HOLDOFF    = 50_000;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE    = 2'd0;
  localparam state_t ST_MEASURE = 2'd1;
  localparam state_t ST_DETECT  = 2'd2;
  localparam state_t ST_HOLDOFF = 2'd3;

endpackage

// File: rtl/us_edge_sync.sv
// rtl/us_edge_sync.sv - 2-flop synchronizer with a registered previous sample and rising-edge flag
module us_edge_sync
  import us_sync_pkg::*;
(
  input  logic i_clock,
  input  logic i_reset,
  input  logic i_din,
  output logic o_rise
);

  logic r_meta;
  logic r_sync;
  logic r_prev;

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_meta <= 1'b0;
      r_sync <= 1'b0;
      r_prev <= 1'b0;
    end else begin
      r_meta <= i_din;
      r_sync <= r_meta;
      r_prev <= r_sync;
    end
  end

  assign o_rise = r_sync & ~r_prev;

endmodule

// File: rtl/us_burst_detector.sv
// rtl/us_burst_detector.sv - qualifies piezo carrier bursts by period and cycle count, emits detect strobe and timestamp
module us_burst_detector
  import us_sync_pkg::*;
#(
  parameter int MIN_PERIOD = DEF_MIN_PERIOD,
  parameter int MAX_PERIOD = DEF_MAX_PERIOD,
  parameter int MIN_CYCLES = DEF_MIN_CYCLES,
  parameter int HOLDOFF    = DEF_HOLDOFF
) (
  input  logic            i_clock,
  input  logic            i_reset,
  input  logic            i_enable,
  input  logic            i_piezo_in,
  output logic            o_detect_pulse,
  output logic [TS_W-1:0] o_detect_time,
  output logic [7:0]      o_reject_cnt,
  output logic            o_busy
);

  localparam int PW = $clog2(MAX_PERIOD + 3);
  localparam int HW = $clog2(HOLDOFF + 1);

  logic            w_rise;
  logic [PW-1:0]   w_period;
  logic            w_in_range;
  logic [7:0]      w_good_next;

  state_t          r_state;
  logic [TS_W-1:0] r_ts_cnt;
  logic [TS_W-1:0] r_start_ts;
  logic [TS_W-1:0] r_detect_time;
  logic [PW-1:0]   r_period_cnt;
  logic [7:0]      r_good_cnt;
  logic [7:0]      r_reject_cnt;
  logic [HW-1:0]   r_hold_cnt;

  us_edge_sync u_edge_sync (
    .i_clock (i_clock),
    .i_reset (i_reset),
    .i_din   (i_piezo_in),
    .o_rise  (w_rise)
  );

  // period_cnt reads one less than the rise-to-rise spacing at the moment a rise lands.
  assign w_period    = r_period_cnt + PW'(1);
  assign w_in_range  = (w_period >= PW'(MIN_PERIOD)) && (w_period <= PW'(MAX_PERIOD));
  assign w_good_next = r_good_cnt + 8'd1;

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_ts_cnt     <= '0;
      r_period_cnt <= '0;
    end else begin
      r_ts_cnt <= r_ts_cnt + TS_W'(1);
      if (w_rise)
        r_period_cnt <= '0;
      else if (r_period_cnt != PW'(MAX_PERIOD + 1))
        r_period_cnt <= r_period_cnt + PW'(1);
    end
  end

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_state       <= ST_IDLE;
      r_start_ts    <= '0;
      r_detect_time <= '0;
      r_good_cnt    <= '0;
      r_reject_cnt  <= '0;
      r_hold_cnt    <= '0;
    end else if (!i_enable) begin
      r_state    <= ST_IDLE;
      r_good_cnt <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_rise) begin
            r_state    <= ST_MEASURE;
            r_start_ts <= r_ts_cnt;
            r_good_cnt <= 8'd1;
          end
        end
        ST_MEASURE: begin
          // A rise coinciding with the timeout still gets its period evaluated.
          if (w_rise) begin
            if (w_in_range) begin
              r_good_cnt <= w_good_next;
              if (w_good_next == 8'(MIN_CYCLES)) begin
                r_state       <= ST_DETECT;
                r_detect_time <= r_start_ts;
              end
            end else begin
              r_start_ts <= r_ts_cnt;
              r_good_cnt <= 8'd1;
              if (r_reject_cnt != 8'hFF)
                r_reject_cnt <= r_reject_cnt + 8'd1;
            end
          end else if (w_period > PW'(MAX_PERIOD)) begin
            r_state    <= ST_IDLE;
            r_good_cnt <= '0;
          end
        end
        ST_DETECT: begin
          r_state    <= ST_HOLDOFF;
          r_hold_cnt <= '0;
          r_good_cnt <= '0;
        end
        ST_HOLDOFF: begin
          if (r_hold_cnt == HW'(HOLDOFF - 1))
            r_state <= ST_IDLE;
          else
            r_hold_cnt <= r_hold_cnt + HW'(1);
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign o_detect_pulse = (r_state == ST_DETECT);
  assign o_detect_time  = r_detect_time;
  assign o_reject_cnt   = r_reject_cnt;
  assign o_busy         = (r_state == ST_MEASURE) || (r_state == ST_HOLDOFF);

endmodule
